// File: rtl/parking_manager_if.sv
// Request/response bundle between the button/tick front end and the parking manager.
interface parking_manager_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int CAP_W     = 3
);
  logic                 tick_1s;
  logic                 entry_signal;
  logic                 exit_signal;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 is_open;
  logic                 is_full;
  logic                 bad_exit;
  logic [NUM_SLOTS-1:0] spots;
  logic [CAP_W-1:0]     capacity;
  logic [SLOT_W-1:0]    location;
  logic [SLOT_W-1:0]    entry_slot;
  logic                 exit_valid;
  logic [6:0]           exit_minutes;
  logic [5:0]           exit_seconds;

  modport master (
    output tick_1s, entry_signal, exit_signal, exit_slot,
    input  is_open, is_full, bad_exit, spots, capacity, location, entry_slot,
           exit_valid, exit_minutes, exit_seconds
  );
  modport slave (
    input  tick_1s, entry_signal, exit_signal, exit_slot,
    output is_open, is_full, bad_exit, spots, capacity, location, entry_slot,
           exit_valid, exit_minutes, exit_seconds
  );
endinterface

// File: rtl/parking_manager.sv
// Parking lot manager: lowest-index-first slot allocation, per-slot stay timers,
// exit duration reporting. All outputs registered, one cycle after the request.
module parking_slot_timer #(
  parameter int TW          = 13,
  parameter int MAX_SECONDS = 5999
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [TW-1:0] t
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              t <= '0;
    else if (clr)                            t <= '0;
    else if (inc && t != TW'(MAX_SECONDS))   t <= t + 1'b1;
  end
endmodule

module parking_manager #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int CAP_W       = 3,
  parameter int MAX_SECONDS = 5999
) (
  input logic              clk,
  input logic              reset,
  parking_manager_if.slave bus
);
  localparam int TW = $clog2(MAX_SECONDS + 1);

  logic [NUM_SLOTS-1:0]         spots_q, spots_nxt, exit_mask, alloc_mask, clr_mask;
  logic [NUM_SLOTS-1:0][TW-1:0] timer;
  logic [TW-1:0]                exit_time;
  logic [CAP_W-1:0]             cap_q;
  logic [SLOT_W-1:0]            free_idx, loc_q, eslot_q;
  logic                         ent_ok, ex_ok;
  logic                         open_q, full_q, bad_q, ev_q;
  logic [6:0]                   min_q;
  logic [5:0]                   sec_q;

  // Lowest clear bit; 0 when every slot is taken.
  function automatic logic [SLOT_W-1:0] low_free(input logic [NUM_SLOTS-1:0] s);
    low_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!s[i]) low_free = SLOT_W'(i);
  endfunction

  always_comb begin
    exit_mask  = '0;
    alloc_mask = '0;
    exit_time  = '0;
    free_idx   = low_free(spots_q);
    ent_ok     = bus.entry_signal && (cap_q != '0);
    // Out-of-range slot indices match no mask bit, so they fall out as invalid.
    for (int i = 0; i < NUM_SLOTS; i++)
      exit_mask[i] = (bus.exit_slot == SLOT_W'(i));
    ex_ok = bus.exit_signal && |(exit_mask & spots_q);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alloc_mask[i] = ent_ok && (free_idx == SLOT_W'(i));
      if (exit_mask[i]) exit_time = timer[i];
    end
    clr_mask  = alloc_mask | (ex_ok ? exit_mask : '0);
    spots_nxt = (spots_q & ~(ex_ok ? exit_mask : '0)) | alloc_mask;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    parking_slot_timer #(.TW(TW), .MAX_SECONDS(MAX_SECONDS)) u_tmr (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_mask[g]),
      .inc   (bus.tick_1s & spots_q[g]),
      .t     (timer[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spots_q <= '0;
      cap_q   <= CAP_W'(NUM_SLOTS);
      loc_q   <= '0;
      eslot_q <= '0;
      open_q  <= 1'b0;
      full_q  <= 1'b0;
      bad_q   <= 1'b0;
      ev_q    <= 1'b0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      spots_q <= spots_nxt;
      cap_q   <= cap_q + CAP_W'(ex_ok) - CAP_W'(ent_ok);
      loc_q   <= low_free(spots_nxt);
      open_q  <= ent_ok | ex_ok;
      full_q  <= bus.entry_signal && !ent_ok;
      bad_q   <= bus.exit_signal && !ex_ok;
      ev_q    <= ex_ok;
      if (ent_ok) eslot_q <= free_idx;
      if (ex_ok) begin
        min_q <= 7'(exit_time / TW'(60));
        sec_q <= 6'(exit_time % TW'(60));
      end
    end
  end

  assign bus.spots        = spots_q;
  assign bus.capacity     = cap_q;
  assign bus.location     = loc_q;
  assign bus.entry_slot   = eslot_q;
  assign bus.is_open      = open_q;
  assign bus.is_full      = full_q;
  assign bus.bad_exit     = bad_q;
  assign bus.exit_valid   = ev_q;
  assign bus.exit_minutes = min_q;
  assign bus.exit_seconds = sec_q;
endmodule

// File: tb/tb_parking_manager.sv
// Scoreboard bench: driver queues hand-computed responses, a negedge monitor pops
// one entry per output pulse cycle on either DUT (4-slot and 3-slot builds).
module tb_parking_manager;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parking_manager_if #(.NUM_SLOTS(4), .SLOT_W(2), .CAP_W(3)) a ();
  parking_manager_if #(.NUM_SLOTS(3), .SLOT_W(2), .CAP_W(2)) b ();

  parking_manager #(.NUM_SLOTS(4), .SLOT_W(2), .CAP_W(3), .MAX_SECONDS(5999)) dut_a (
    .clk(clk), .reset(rst_n), .bus(a));
  parking_manager #(.NUM_SLOTS(3), .SLOT_W(2), .CAP_W(2), .MAX_SECONDS(5999)) dut_b (
    .clk(clk), .reset(rst_n), .bus(b));

  typedef struct packed {
    logic       open, full, bad, ev;
    logic [3:0] spots;
    logic [2:0] cap;
    logic [1:0] loc, es;
    logic [6:0] mn;
    logic [5:0] sc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [3:0] p, input logic [3:0] s, input int cap,
                              input int loc, input int es, input int mn, input int sc);
    mk = '{open: p[3], full: p[2], bad: p[1], ev: p[0], spots: s, cap: 3'(cap),
           loc: 2'(loc), es: 2'(es), mn: 7'(mn), sc: 6'(sc)};
  endfunction

  function automatic exp_t obs_a();
    obs_a = '{open: a.is_open, full: a.is_full, bad: a.bad_exit, ev: a.exit_valid,
              spots: a.spots, cap: a.capacity, loc: a.location, es: a.entry_slot,
              mn: a.exit_minutes, sc: a.exit_seconds};
  endfunction

  function automatic exp_t obs_b();
    obs_b = '{open: b.is_open, full: b.is_full, bad: b.bad_exit, ev: b.exit_valid,
              spots: {1'b0, b.spots}, cap: {1'b0, b.capacity}, loc: b.location,
              es: b.entry_slot, mn: b.exit_minutes, sc: b.exit_seconds};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with an output pulse consumes one expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a.is_open | a.is_full | a.bad_exit | a.exit_valid) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut_a unexpected pulse: got %h expected none", obs_a());
        end else check($sformatf("dut_a resp#%0d", checks), 32'(obs_a()), 32'(qa.pop_front()));
      end
      if (b.is_open | b.is_full | b.bad_exit | b.exit_valid) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut_b unexpected pulse: got %h expected none", obs_b());
        end else check($sformatf("dut_b resp#%0d", checks), 32'(obs_b()), 32'(qb.pop_front()));
      end
    end
  end

  task automatic req(input bit on_b, input logic en, input logic ex, input int sl,
                     input logic tk, input exp_t e);
    @(posedge clk); #1;
    if (on_b) begin
      b.entry_signal = en; b.exit_signal = ex; b.exit_slot = 2'(sl); b.tick_1s = tk;
      qb.push_back(e);
    end else begin
      a.entry_signal = en; a.exit_signal = ex; a.exit_slot = 2'(sl); a.tick_1s = tk;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    a.entry_signal = 0; a.exit_signal = 0; a.tick_1s = 0;
    b.entry_signal = 0; b.exit_signal = 0; b.tick_1s = 0;
  endtask

  task automatic ticks(input int n);
    @(posedge clk); #1 a.tick_1s = 1;
    repeat (n) @(posedge clk);
    #1 a.tick_1s = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++) @(posedge clk);
    check(name, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    a.entry_signal = 0; a.exit_signal = 0; a.exit_slot = 0; a.tick_1s = 0;
    b.entry_signal = 0; b.exit_signal = 0; b.exit_slot = 0; b.tick_1s = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1 check("reset_a", 32'(obs_a()), 32'(mk(4'b0000, 4'b0000, 4, 0, 0, 0, 0)));

    // Fill the lot, then one rejected entry
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0011, 2, 2, 1, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0111, 1, 3, 2, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b1111, 0, 0, 3, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b0100, 4'b1111, 0, 0, 3, 0, 0));
    // Hole at slot 1 is refilled first
    req(0, 0, 1, 1, 0, mk(4'b1001, 4'b1101, 1, 1, 3, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b1111, 0, 0, 1, 0, 0));
    // Simultaneous entry/exit: freed slot 2 not reusable that cycle
    req(0, 0, 1, 3, 0, mk(4'b1001, 4'b0111, 1, 3, 1, 0, 0));
    req(0, 1, 1, 2, 0, mk(4'b1001, 4'b1011, 1, 2, 3, 0, 0));
    req(0, 0, 1, 2, 0, mk(4'b0010, 4'b1011, 1, 2, 3, 0, 0));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b1111, 0, 0, 2, 0, 0));
    // Full lot: entry rejected though exit is valid
    req(0, 1, 1, 0, 0, mk(4'b1101, 4'b1110, 1, 0, 2, 0, 0));
    req(0, 0, 1, 1, 0, mk(4'b1001, 4'b1100, 2, 0, 2, 0, 0));
    req(0, 0, 1, 2, 0, mk(4'b1001, 4'b1000, 3, 0, 2, 0, 0));
    req(0, 0, 1, 3, 0, mk(4'b1001, 4'b0000, 4, 0, 2, 0, 0));
    // 125 s stay -> 2:05, then timer restarts from zero
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 0, 0));
    ticks(125);
    req(0, 0, 1, 0, 0, mk(4'b1001, 4'b0000, 4, 0, 0, 2, 5));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 2, 5));
    req(0, 0, 1, 0, 0, mk(4'b1001, 4'b0000, 4, 0, 0, 0, 0));
    // Tick coincident with exit is not counted
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 0, 0));
    ticks(3);
    req(0, 0, 1, 0, 1, mk(4'b1001, 4'b0000, 4, 0, 0, 0, 3));
    // Saturation at 99:59
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 0, 3));
    ticks(6100);
    req(0, 0, 1, 0, 0, mk(4'b1001, 4'b0000, 4, 0, 0, 99, 59));
    // Two cars parked, then asynchronous reset mid-cycle
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 3, 1, 0, 99, 59));
    req(0, 1, 0, 0, 0, mk(4'b1000, 4'b0011, 2, 2, 1, 99, 59));
    drain("drain_a");
    @(posedge clk); #3 rst_n = 0;
    #1 check("async_reset_a", 32'(obs_a()), 32'(mk(4'b0000, 4'b0000, 4, 0, 0, 0, 0)));
    @(posedge clk); #1 rst_n = 1;
    #1 check("reset_b", 32'(obs_b()), 32'(mk(4'b0000, 4'b0000, 3, 0, 0, 0, 0)));

    // 3-slot build: slot index 3 is out of range
    req(1, 0, 1, 3, 0, mk(4'b0010, 4'b0000, 3, 0, 0, 0, 0));
    req(1, 1, 0, 0, 0, mk(4'b1000, 4'b0001, 2, 1, 0, 0, 0));
    req(1, 0, 1, 3, 0, mk(4'b0010, 4'b0001, 2, 1, 0, 0, 0));
    req(1, 1, 0, 0, 0, mk(4'b1000, 4'b0011, 1, 2, 1, 0, 0));
    req(1, 1, 0, 0, 0, mk(4'b1000, 4'b0111, 0, 0, 2, 0, 0));
    req(1, 1, 0, 0, 0, mk(4'b0100, 4'b0111, 0, 0, 2, 0, 0));
    req(1, 0, 1, 3, 0, mk(4'b0010, 4'b0111, 0, 0, 2, 0, 0));
    req(1, 0, 1, 1, 0, mk(4'b1001, 4'b0101, 1, 1, 2, 0, 0));
    drain("drain_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/parking_manager.md
Name: parking_manager

Overview:
Parametrised successor to the fixed 4-slot parking controller. Manages NUM_SLOTS spots with lowest-index-first allocation. Keeps a per-slot parked-time counter driven by a 1 Hz tick, and reports the stay duration (minutes/seconds) on each valid exit. Sits between the debounced button pulses and the door/full LED blinkers and the multiplexed display, replacing the hard-wired time inputs.

Parameters:
NUM_SLOTS, 4, number of parking spots (2..16)
SLOT_W, 2, width of slot indices; must satisfy 2**SLOT_W >= NUM_SLOTS
CAP_W, 3, width of capacity; must hold the value NUM_SLOTS
MAX_SECONDS, 5999, saturation value of each per-slot timer (99:59)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick_1s  input  1  one-clk pulse once per second
entry_signal  input  1  one-clk pulse: car requests entry
exit_signal  input  1  one-clk pulse: car requests exit
exit_slot  input  SLOT_W  slot index of exiting car, sampled with exit_signal
is_open  output  1  one-clk pulse: door opens (accepted entry or exit)
is_full  output  1  one-clk pulse: entry rejected, lot full
bad_exit  output  1  one-clk pulse: exit from empty or out-of-range slot
spots  output  NUM_SLOTS  occupancy bitmap (1 = occupied)
capacity  output  CAP_W  free slots remaining
location  output  SLOT_W  lowest-index free slot (0 when full)
entry_slot  output  SLOT_W  slot assigned by the last accepted entry
exit_valid  output  1  one-clk pulse: exit_minutes/exit_seconds valid
exit_minutes  output  7  stay duration, minutes (0..99)
exit_seconds  output  6  stay duration, seconds (0..59)

Behaviour:
- Reset (async, reset=0):
  - spots=0, capacity=NUM_SLOTS, location=0, entry_slot=0.
  - All pulses 0; exit_minutes=0, exit_seconds=0.
  - All slot timers 0.
  - Takes effect immediately, including mid-operation.
- All outputs are registered. Requests sampled at edge t appear at edge t+1 (1-cycle latency). Pulse outputs are high for exactly one cycle.
- Entry handling:
  - If capacity==0: is_full=1; no state change.
  - Otherwise: slot L = lowest free index of the pre-edge spots. Set spots[L]; clear timer[L] to 0; capacity-1; entry_slot=L; is_open=1.
- Exit handling, valid when exit_slot<NUM_SLOTS and spots[exit_slot]=1:
  - Clear spots[exit_slot]; capacity+1; is_open=1; exit_valid=1.
  - exit_minutes = timer/60, exit_seconds = timer%60, using the pre-edge timer value. A tick in the same cycle does not add to the reported time.
  - Slot timer is cleared to 0.
- Exit handling, invalid: bad_exit=1; no state change.
- Simultaneous entry and exit (same cycle):
  - Both are evaluated against the pre-edge state.
  - A valid exit plus an accepted entry leaves capacity unchanged.
  - The slot freed that cycle is not available to the same-cycle entry.
  - If capacity==0, the entry is rejected (is_full) even when the exit is valid.
  - is_open is a single pulse even if both requests are accepted.
- Timers: on tick_1s, every occupied slot's timer increments by 1 and saturates at MAX_SECONDS. Free slots hold 0. Timer width is ceil(log2(MAX_SECONDS+1)).
- location: registered; lowest free index of the post-edge spots; 0 when capacity==0.
- Invariant: capacity == NUM_SLOTS − popcount(spots) at all times.
- exit_minutes/exit_seconds hold their last values between exit_valid pulses.

Test Plan:
- Reset, then 4 entry pulses (NUM_SLOTS=4) → entry_slot 0,1,2,3; spots=1111; capacity=0; 4 is_open pulses. 5th entry → is_full pulse; spots unchanged.
- Park slot 0, apply 125 tick_1s pulses, exit slot 0 → exit_valid with exit_minutes=2, exit_seconds=5; capacity back to 4; timer[0]=0.
- spots=1111, exit slot 1 → spots=1101, location=1. Next entry → entry_slot=1, spots=1111.
- spots=0111, simultaneous entry and exit of slot 2 → spots=1011; capacity=1; single is_open pulse.
- Exit of empty slot 3, and (NUM_SLOTS=3) exit_slot=3 → bad_exit pulse; spots and capacity unchanged.
- Park 1 car, apply 6100 ticks, exit → 99:59 (saturation). Separately, assert reset mid-stream with 2 cars parked → all outputs return to reset values immediately.
